demux_1a2_reg: RTL and testbench
================================

Name: demux_1a2_reg

Overview:
- Registered 1-to-2 demultiplexer: the write-side counterpart of the operand-source mux.
- Routes a WIDTH-bit datapath word, such as an ALU result, to one of two destinations, for example the register file or the memory write port.
- Selection is by DEST_SEL.
- Each destination has its own DEPTH-entry FIFO and a valid/ready handshake, so a stalled destination does not corrupt or drop data.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per destination FIFO; must be a power of two and at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Entrada  input  WIDTH  input data word.
- Entrada_valid  input  1  Entrada and DEST_SEL are valid this cycle.
- DEST_SEL  input  1  0 routes to Salida1, 1 routes to Salida2.
- Entrada_ready  output  1  the selected FIFO can accept a word.
- Salida1  output  WIDTH  head word of FIFO 1.
- Salida1_valid  output  1  FIFO 1 is not empty.
- Salida1_ready  input  1  consumer 1 takes the head word.
- Salida2  output  WIDTH  head word of FIFO 2.
- Salida2_valid  output  1  FIFO 2 is not empty.
- Salida2_ready  input  1  consumer 2 takes the head word.
- Cuenta1  output  CW  occupancy of FIFO 1.
- Cuenta2  output  CW  occupancy of FIFO 2.

Behaviour:
- Reset:
  - rst_n=0 asynchronously clears both pointer pairs, Cuenta1/2 and the valid flags.
  - Salida1 and Salida2 read 0 while in reset.
  - Storage contents are don't-care but must never be presented while the matching valid flag is 0.
- Reset mid-operation: all queued words are discarded and there is no partial transfer. The first rising edge after rst_n rises behaves as the post-reset state.
- Input acceptance (push):
  - Entrada_ready = !full(DEST_SEL), a pure combinational function of DEST_SEL and the FIFO state.
  - Entrada_ready must not depend on Salida*_ready, so there is no combinational path from output to input.
  - A push occurs on an edge where Entrada_valid && Entrada_ready; the word is written to the FIFO chosen by DEST_SEL.
- Output removal (pop): a pop of FIFO n occurs on an edge where Salidan_valid && Salidan_ready.
- Latency: a word pushed into an empty FIFO appears on Salidan with Salidan_valid=1 one cycle after the accepting edge. There is no combinational bypass.
- Ordering: FIFO order within each destination. No ordering is defined between destinations.
- Simultaneous push and pop, same FIFO, not full: both take effect and Cuenta is unchanged.
- Simultaneous push and pop, same FIFO, full: the pop takes effect, the push is refused because Entrada_ready was 0, and Cuenta decrements.
- Push to one FIFO with pop from the other in the same cycle: independent; each count changes by ±1.
- Empty FIFO: Salidan_valid=0 and Salidan_ready is ignored. Count and pointers hold, with no underflow.
- Full FIFO: Cuenta=DEPTH.
- Pointers: log2(DEPTH)-bit pointers that wrap modulo DEPTH. Full and empty are derived from Cuenta only.
- Salidan always shows the entry at the read pointer. When Salidan_valid=1 it is stable until popped.
- If Entrada_valid=0, DEST_SEL and Entrada are don't-care and no state changes from the input side.
- Per-FIFO state is EMPTY / PARTIAL / FULL, derived from Cuenta:
  - EMPTY→PARTIAL on push only.
  - PARTIAL→FULL on push only at Cuenta=DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop only at Cuenta=1.
  - All other combinations hold.

Test Plan:
- Reset then idle (DEPTH=2): hold rst_n=0 for 3 cycles, release → Salida1/2_valid=0, Cuenta1/2=0, Entrada_ready=1 for both DEST_SEL values.
- Basic routing:
  - Entrada=32'h2, DEST_SEL=0, valid for one cycle → next cycle Salida1=2, Salida1_valid=1, Cuenta1=1, Salida2_valid=0.
  - Then Entrada=32'h1, DEST_SEL=1 → Salida2=1, Cuenta2=1, and Salida1 is still 2.
- Fill and backpressure:
  - Salida1_ready=0; push 10, 11, 12 with DEST_SEL=0 → 10 and 11 accepted, Cuenta1=2.
  - Entrada_ready=0 while 12 is presented and DEST_SEL=0; with DEST_SEL=1 at the same state, Entrada_ready=1.
- Full with simultaneous pop:
  - FIFO1 full with 10, 11; Salida1_ready=1 and push 12 in the same cycle → pop of 10 only, Cuenta1=1, 12 not accepted.
  - Next cycle 12 is accepted with Cuenta1 unchanged at 1 (push+pop), and the output order is 11 then 12.
- Wrap-around and concurrent traffic:
  - Stream 20 words alternating DEST_SEL with random Salida1/2_ready.
  - Expected: each destination receives its words in order, none lost or duplicated, Cuenta never exceeds DEPTH, and pointers wrap at least 4 times.
- Reset mid-operation: with Cuenta1=2 and Cuenta2=1, pulse rst_n low for half a cycle, not aligned to clk → outputs clear immediately, and after release the first pushed word 32'hA5 appears alone with Cuenta=1.

Source files
------------

// File: rtl/demux_1a2_reg.sv
// Registered 1-to-2 demultiplexer. It routes each input word to one of two
// DEPTH-entry FIFOs, and each FIFO drives its own valid/ready output port.
`timescale 1ns/1ps
module demux_1a2_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             Entrada_valid,
  input  logic             DEST_SEL,
  output logic             Entrada_ready,
  output logic [WIDTH-1:0] Salida1,
  output logic             Salida1_valid,
  input  logic             Salida1_ready,
  output logic [WIDTH-1:0] Salida2,
  output logic             Salida2_valid,
  input  logic             Salida2_ready,
  output logic [CW-1:0]    Cuenta1,
  output logic [CW-1:0]    Cuenta2
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  logic [WIDTH-1:0]       mem_q [2][DEPTH];
  logic [1:0][PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0][PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  fifo_state_e            fifo_state [2];
  logic [1:0]             full, empty, push, pop, out_ready;

  assign out_ready = {Salida2_ready, Salida1_ready};

  // The FIFO state is a pure function of the occupancy count. It keeps no
  // register of its own, so it can never disagree with Cuenta.
  always_comb begin
    // NOTE: every variable gets a value before any branch. A path that
    // assigned nothing would make synthesis infer a latch.
    full  = '0;
    empty = '0;
    for (int i = 0; i < 2; i++) begin
      fifo_state[i] = ST_PARTIAL;
      if (cnt_q[i] == '0)
        fifo_state[i] = ST_EMPTY;
      else if (cnt_q[i] == CW'(DEPTH))
        fifo_state[i] = ST_FULL;
      full[i]  = (fifo_state[i] == ST_FULL);
      empty[i] = (fifo_state[i] == ST_EMPTY);
    end
  end

  // Ready looks only at the selected FIFO's own count. It never looks at the
  // consumer ready inputs, so no combinational path runs from output to input.
  assign Entrada_ready = !full[DEST_SEL];

  always_comb begin
    push     = '0;
    pop      = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      push[i] = Entrada_valid && Entrada_ready && (DEST_SEL == 1'(i));
      pop[i]  = !empty[i] && out_ready[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its pre-edge value, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents matter only while the
  // count says they are valid, and the output gating below hides them otherwise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= Entrada;
  end

  assign Salida1_valid = !empty[0];
  assign Salida2_valid = !empty[1];
  assign Salida1       = Salida1_valid ? mem_q[0][rd_ptr_q[0]] : '0;
  assign Salida2       = Salida2_valid ? mem_q[1][rd_ptr_q[1]] : '0;
  assign Cuenta1       = cnt_q[0];
  assign Cuenta2       = cnt_q[1];

endmodule

// File: tb/tb_demux_1a2_reg.sv
// Directed bench for demux_1a2_reg (DEPTH=2). Each scenario task drives its
// own stimulus and compares the outputs against hand-computed values.
`timescale 1ns/1ps
module tb_demux_1a2_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] Entrada;
  logic             Entrada_valid;
  logic             DEST_SEL;
  logic             Entrada_ready;
  logic [WIDTH-1:0] Salida1, Salida2;
  logic             Salida1_valid, Salida2_valid;
  logic             Salida1_ready, Salida2_ready;
  logic [CW-1:0]    Cuenta1, Cuenta2;

  int checks = 0;
  int errors = 0;

  demux_1a2_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Entrada       (Entrada),
    .Entrada_valid (Entrada_valid),
    .DEST_SEL      (DEST_SEL),
    .Entrada_ready (Entrada_ready),
    .Salida1       (Salida1),
    .Salida1_valid (Salida1_valid),
    .Salida1_ready (Salida1_ready),
    .Salida2       (Salida2),
    .Salida2_valid (Salida2_valid),
    .Salida2_ready (Salida2_ready),
    .Cuenta1       (Cuenta1),
    .Cuenta2       (Cuenta2)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Entrada = '0; Entrada_valid = 1'b0; DEST_SEL = 1'b0;
    Salida1_ready = 1'b0; Salida2_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (Salida1 !== 32'h0 || Salida2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: Salida1=%h Salida2=%h required 0/0", Salida1, Salida2);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (Salida1_valid !== 1'b0 || Salida2_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b required 0/0", Salida1_valid, Salida2_valid);
    end
    checks++;
    if (Cuenta1 !== 2'd0 || Cuenta2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", Cuenta1, Cuenta2);
    end
    DEST_SEL = 1'b0; #1;
    checks++;
    if (Entrada_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_sel0: got %b required 1", Entrada_ready);
    end
    DEST_SEL = 1'b1; #1;
    checks++;
    if (Entrada_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_sel1: got %b required 1", Entrada_ready);
    end
  endtask

  task automatic test_routing();
    Entrada = 32'h2; DEST_SEL = 1'b0; Entrada_valid = 1'b1;
    step();
    Entrada_valid = 1'b0;
    checks++;
    if (Salida1 !== 32'h2 || Salida1_valid !== 1'b1 || Cuenta1 !== 2'd1 || Salida2_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_to_1: Salida1=%h v1=%b Cuenta1=%0d v2=%b required 2/1/1/0",
               Salida1, Salida1_valid, Cuenta1, Salida2_valid);
    end
    Entrada = 32'h1; DEST_SEL = 1'b1; Entrada_valid = 1'b1;
    step();
    Entrada_valid = 1'b0;
    checks++;
    if (Salida2 !== 32'h1 || Salida2_valid !== 1'b1 || Cuenta2 !== 2'd1 || Salida1 !== 32'h2) begin
      errors++;
      $display("FAIL route_to_2: Salida2=%h v2=%b Cuenta2=%0d Salida1=%h required 1/1/1/2",
               Salida2, Salida2_valid, Cuenta2, Salida1);
    end
    // Drain both FIFOs, then pop once more while empty to show no underflow.
    Salida1_ready = 1'b1; Salida2_ready = 1'b1;
    step();
    step();
    Salida1_ready = 1'b0; Salida2_ready = 1'b0;
    checks++;
    if (Cuenta1 !== 2'd0 || Cuenta2 !== 2'd0 || Salida1_valid !== 1'b0 || Salida2_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: Cuenta=%0d/%0d valid=%b/%b required 0/0 0/0",
               Cuenta1, Cuenta2, Salida1_valid, Salida2_valid);
    end
  endtask

  task automatic test_fill_backpressure();
    Salida1_ready = 1'b0; DEST_SEL = 1'b0; Entrada_valid = 1'b1;
    Entrada = 32'd10; step();
    Entrada = 32'd11; step();
    Entrada = 32'd12; #1;
    checks++;
    if (Entrada_ready !== 1'b0 || Cuenta1 !== 2'd2) begin
      errors++;
      $display("FAIL full_ready_sel0: ready=%b Cuenta1=%0d required 0/2", Entrada_ready, Cuenta1);
    end
    DEST_SEL = 1'b1; #1;
    checks++;
    if (Entrada_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_sel1: ready=%b required 1", Entrada_ready);
    end
    DEST_SEL = 1'b0;
    step();
    checks++;
    if (Cuenta1 !== 2'd2 || Salida1 !== 32'd10 || Cuenta2 !== 2'd0) begin
      errors++;
      $display("FAIL refused_push: Cuenta1=%0d Salida1=%0d Cuenta2=%0d required 2/10/0",
               Cuenta1, Salida1, Cuenta2);
    end
  endtask

  task automatic test_full_pop();
    // FIFO1 holds 10, 11. Word 12 stays presented while the consumer pops.
    Salida1_ready = 1'b1; Entrada = 32'd12; DEST_SEL = 1'b0; Entrada_valid = 1'b1;
    step();
    checks++;
    if (Cuenta1 !== 2'd1 || Salida1 !== 32'd11) begin
      errors++;
      $display("FAIL full_pop: Cuenta1=%0d Salida1=%0d required 1/11", Cuenta1, Salida1);
    end
    step();
    Entrada_valid = 1'b0;
    checks++;
    if (Cuenta1 !== 2'd1 || Salida1 !== 32'd12) begin
      errors++;
      $display("FAIL push_pop: Cuenta1=%0d Salida1=%0d required 1/12", Cuenta1, Salida1);
    end
    step();
    checks++;
    if (Cuenta1 !== 2'd0 || Salida1_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_pop: Cuenta1=%0d v1=%b required 0/0", Cuenta1, Salida1_valid);
    end
    step();
    checks++;
    if (Cuenta1 !== 2'd0) begin
      errors++; $display("FAIL empty_pop: Cuenta1=%0d required 0", Cuenta1);
    end
    Salida1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] q1[$], q2[$];
    int sent = 0, popped = 0, cyc = 0;
    logic r1, r2, acc, exp_ready;
    while ((sent < 20 || q1.size() != 0 || q2.size() != 0) && cyc < 300) begin
      Entrada_valid = (sent < 20);
      Entrada       = 32'h100 + sent;
      DEST_SEL      = sent[0];
      r1 = (sent >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      r2 = (sent >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      Salida1_ready = r1; Salida2_ready = r2;
      #1;
      exp_ready = DEST_SEL ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
      checks++;
      if (Cuenta1 !== CW'(q1.size()) || Cuenta2 !== CW'(q2.size()) || Entrada_ready !== exp_ready) begin
        errors++;
        $display("FAIL stream_state cyc %0d: Cuenta=%0d/%0d ready=%b required %0d/%0d/%b",
                 cyc, Cuenta1, Cuenta2, Entrada_ready, q1.size(), q2.size(), exp_ready);
      end
      checks++;
      if (Salida1_valid !== (q1.size() != 0) || (q1.size() != 0 && Salida1 !== q1[0])) begin
        errors++;
        $display("FAIL stream_out1 cyc %0d: Salida1=%h v=%b required %h v=%b",
                 cyc, Salida1, Salida1_valid, (q1.size() != 0) ? q1[0] : '0, q1.size() != 0);
      end
      checks++;
      if (Salida2_valid !== (q2.size() != 0) || (q2.size() != 0 && Salida2 !== q2[0])) begin
        errors++;
        $display("FAIL stream_out2 cyc %0d: Salida2=%h v=%b required %h v=%b",
                 cyc, Salida2, Salida2_valid, (q2.size() != 0) ? q2[0] : '0, q2.size() != 0);
      end
      acc = Entrada_valid && exp_ready;
      if (r1 && q1.size() != 0) begin void'(q1.pop_front()); popped++; end
      if (r2 && q2.size() != 0) begin void'(q2.pop_front()); popped++; end
      if (acc) begin
        if (DEST_SEL) q2.push_back(Entrada); else q1.push_back(Entrada);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    Entrada_valid = 1'b0; Salida1_ready = 1'b0; Salida2_ready = 1'b0;
    checks++;
    if (popped != 20 || cyc >= 300) begin
      errors++;
      $display("FAIL stream_total: popped %0d in %0d cycles required 20 within 300", popped, cyc);
    end
    checks++;
    if (Cuenta1 !== 2'd0 || Cuenta2 !== 2'd0) begin
      errors++;
      $display("FAIL stream_end: Cuenta=%0d/%0d required 0/0", Cuenta1, Cuenta2);
    end
  endtask

  task automatic test_reset_mid_op();
    Salida1_ready = 1'b0; Salida2_ready = 1'b0; Entrada_valid = 1'b1;
    DEST_SEL = 1'b0; Entrada = 32'h31; step();
    Entrada = 32'h32; step();
    DEST_SEL = 1'b1; Entrada = 32'h33; step();
    Entrada_valid = 1'b0;
    checks++;
    if (Cuenta1 !== 2'd2 || Cuenta2 !== 2'd1) begin
      errors++;
      $display("FAIL preload: Cuenta=%0d/%0d required 2/1", Cuenta1, Cuenta2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Cuenta1 !== 2'd0 || Cuenta2 !== 2'd0 || Salida1_valid !== 1'b0 || Salida2_valid !== 1'b0 ||
        Salida1 !== 32'h0 || Salida2 !== 32'h0) begin
      errors++;
      $display("FAIL async_clear: Cuenta=%0d/%0d valid=%b/%b data=%h/%h required all 0",
               Cuenta1, Cuenta2, Salida1_valid, Salida2_valid, Salida1, Salida2);
    end
    #4 rst_n = 1'b1;
    step();
    Entrada = 32'hA5; DEST_SEL = 1'b0; Entrada_valid = 1'b1;
    step();
    Entrada_valid = 1'b0;
    checks++;
    if (Salida1 !== 32'hA5 || Cuenta1 !== 2'd1 || Cuenta2 !== 2'd0 || Salida2_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_push: Salida1=%h Cuenta=%0d/%0d v2=%b required a5 1/0 0",
               Salida1, Cuenta1, Cuenta2, Salida2_valid);
    end
    Salida1_ready = 1'b1;
    step();
    Salida1_ready = 1'b0;
    checks++;
    if (Cuenta1 !== 2'd0 || Salida1_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_alone: Cuenta1=%0d v1=%b required 0/0", Cuenta1, Salida1_valid);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_fill_backpressure();
    test_full_pop();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
